// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction
// memory port and loads the IF/ID pipeline register with the fetched
// instruction or a bubble. Also keeps a saturating count of accepted fetches.
module inst_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_en,
    input  logic [15:0] branch_target,
    input  logic        mem_busy,
    output logic [15:0] mem_pc,
    input  logic [15:0] mem_inst,
    output logic [15:0] if_id_pc,
    output logic [15:0] if_id_inst,
    output logic        if_id_valid,
    output logic [15:0] fetch_cnt
);

    localparam int unsigned PC_W   = 16;
    localparam int unsigned INST_W = 16;
    localparam int unsigned CNT_W  = 16;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [PC_W-1:0]   pc_q,       pc_d;
    logic [PC_W-1:0]   id_pc_q,    id_pc_d;
    logic [INST_W-1:0] id_inst_q,  id_inst_d;
    logic              id_valid_q, id_valid_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;

    // Next-state selection; branch beats stall, stall beats busy.
    always_comb begin
        pc_d       = pc_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
        cnt_d      = cnt_q;

        if (branch_en) begin
            // Wrong-path instruction at the old PC is dropped uncounted.
            pc_d       = branch_target;
            id_pc_d    = '0;
            id_inst_d  = NOP_INST;
            id_valid_d = 1'b0;
        end else if (stall) begin
            // Everything holds.
        end else if (mem_busy) begin
            id_pc_d    = '0;
            id_inst_d  = NOP_INST;
            id_valid_d = 1'b0;
        end else begin
            pc_d       = PC_W'(pc_q + PC_W'(1));
            id_pc_d    = PC_W'(pc_q + PC_W'(1));
            id_inst_d  = mem_inst;
            id_valid_d = 1'b1;
            if (cnt_q != CNT_MAX) begin
                cnt_d = CNT_W'(cnt_q + CNT_W'(1));
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            id_pc_q    <= '0;
            id_inst_q  <= NOP_INST;
            id_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign mem_pc      = pc_q;
    assign if_id_pc    = id_pc_q;
    assign if_id_inst  = id_inst_q;
    assign if_id_valid = id_valid_q;
    assign fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus randomized
// traffic against a cycle-level behavioural model of the fetch stage.
module tb_inst_fetch;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_en = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic        mem_busy = 1'b0;
    logic [15:0] mem_pc;
    logic [15:0] mem_inst;
    logic [15:0] if_id_pc;
    logic [15:0] if_id_inst;
    logic        if_id_valid;
    logic [15:0] fetch_cnt;

    logic [15:0] mem [0:65535];

    // Behavioural model state.
    logic [15:0] m_pc, m_ipc, m_inst, m_cnt;
    logic        m_val;

    int n_cmp = 0;
    int n_bad = 0;

    inst_fetch #(.RESET_PC(16'h0000), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_en(branch_en),
        .branch_target(branch_target), .mem_busy(mem_busy), .mem_pc(mem_pc),
        .mem_inst(mem_inst), .if_id_pc(if_id_pc), .if_id_inst(if_id_inst),
        .if_id_valid(if_id_valid), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    assign mem_inst = mem[mem_pc];

    // Apply one cycle of inputs, advance the model at the edge, settle.
    task automatic step(input logic r, input logic b, input logic [15:0] t,
                        input logic s, input logic bz);
        rst = r; branch_en = b; branch_target = t; stall = s; mem_busy = bz;
        @(posedge clk);
        if (r) begin
            m_pc = 16'h0000; m_ipc = 16'h0000; m_inst = NOP; m_val = 1'b0; m_cnt = 16'h0000;
        end else if (b) begin
            m_pc = t; m_ipc = 16'h0000; m_inst = NOP; m_val = 1'b0;
        end else if (s) begin
            // hold
        end else if (bz) begin
            m_ipc = 16'h0000; m_inst = NOP; m_val = 1'b0;
        end else begin
            m_inst = mem[m_pc];
            m_pc   = (m_pc + 16'd1) & 16'hFFFF;
            m_ipc  = m_pc;
            m_val  = 1'b1;
            m_cnt  = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
        end
        #1;
    endtask

    task automatic do_reset();
        step(1, 0, 16'h0000, 0, 0);
        step(1, 0, 16'h0000, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (mem_pc !== 16'h0000 || if_id_pc !== 16'h0000 || if_id_inst !== NOP ||
            if_id_valid !== 1'b0 || fetch_cnt !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset: got pc=%h ipc=%h inst=%h v=%b cnt=%h, want 0000 0000 %h 0 0000",
                     mem_pc, if_id_pc, if_id_inst, if_id_valid, fetch_cnt, NOP);
        end
    endtask

    task automatic test_straight_line();
        logic [15:0] exp_inst [3];
        exp_inst[0] = 16'h6801; exp_inst[1] = 16'h6902; exp_inst[2] = 16'h6A03;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 16'h0000, 0, 0);
            n_cmp++;
            if (if_id_pc !== 16'(i + 1) || if_id_inst !== exp_inst[i] || if_id_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL straight[%0d]: got (%h,%h,%b) want (%h,%h,1)", i,
                         if_id_pc, if_id_inst, if_id_valid, 16'(i + 1), exp_inst[i]);
            end
        end
        n_cmp++;
        if (fetch_cnt !== 16'd3) begin
            n_bad++;
            $display("FAIL straight_cnt: got %h want 0003", fetch_cnt);
        end
    endtask

    task automatic test_stall();
        do_reset();
        step(0, 0, 16'h0000, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 16'h0000, 1, (i == 1));
            n_cmp++;
            if (if_id_pc !== 16'h0001 || if_id_inst !== 16'h6801 || if_id_valid !== 1'b1 ||
                mem_pc !== 16'h0001 || fetch_cnt !== 16'd1) begin
                n_bad++;
                $display("FAIL stall_hold[%0d]: got (%h,%h,%b) pc=%h cnt=%h want (0001,6801,1) pc=0001 cnt=0001",
                         i, if_id_pc, if_id_inst, if_id_valid, mem_pc, fetch_cnt);
            end
        end
        step(0, 0, 16'h0000, 0, 0);
        n_cmp++;
        if (if_id_pc !== 16'h0002 || if_id_inst !== 16'h6902 || if_id_valid !== 1'b1 ||
            fetch_cnt !== 16'd2) begin
            n_bad++;
            $display("FAIL stall_release: got (%h,%h,%b) cnt=%h want (0002,6902,1) cnt=0002",
                     if_id_pc, if_id_inst, if_id_valid, fetch_cnt);
        end
    endtask

    task automatic test_busy();
        do_reset();
        step(0, 0, 16'h0000, 0, 0);
        step(0, 0, 16'h0000, 0, 1);
        n_cmp++;
        if (if_id_inst !== NOP || if_id_valid !== 1'b0 || if_id_pc !== 16'h0000 ||
            mem_pc !== 16'h0001 || fetch_cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL busy_bubble: got (%h,%h,%b) pc=%h cnt=%h want (0000,%h,0) pc=0001 cnt=0001",
                     if_id_pc, if_id_inst, if_id_valid, mem_pc, fetch_cnt, NOP);
        end
        step(0, 0, 16'h0000, 0, 0);
        n_cmp++;
        if (if_id_pc !== 16'h0002 || if_id_inst !== 16'h6902 || if_id_valid !== 1'b1 ||
            fetch_cnt !== 16'd2) begin
            n_bad++;
            $display("FAIL busy_resume: got (%h,%h,%b) cnt=%h want (0002,6902,1) cnt=0002",
                     if_id_pc, if_id_inst, if_id_valid, fetch_cnt);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        repeat (5) step(0, 0, 16'h0000, 0, 0);
        step(0, 1, 16'h0002, 1, 1);
        n_cmp++;
        if (mem_pc !== 16'h0002 || if_id_inst !== NOP || if_id_valid !== 1'b0 ||
            if_id_pc !== 16'h0000 || fetch_cnt !== 16'd5) begin
            n_bad++;
            $display("FAIL redirect_bubble: got (%h,%h,%b) pc=%h cnt=%h want (0000,%h,0) pc=0002 cnt=0005",
                     if_id_pc, if_id_inst, if_id_valid, mem_pc, fetch_cnt, NOP);
        end
        step(0, 0, 16'h0000, 0, 0);
        n_cmp++;
        if (if_id_pc !== 16'h0003 || if_id_inst !== 16'h6A03 || if_id_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL redirect_target: got (%h,%h,%b) want (0003,6A03,1)",
                     if_id_pc, if_id_inst, if_id_valid);
        end
    endtask

    task automatic test_wrap();
        step(0, 1, 16'hFFFF, 0, 0);
        step(0, 0, 16'h0000, 0, 0);
        n_cmp++;
        if (if_id_pc !== 16'h0000 || mem_pc !== 16'h0000 || if_id_inst !== mem[65535] ||
            if_id_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap: got ipc=%h pc=%h inst=%h v=%b want ipc=0000 pc=0000 inst=%h v=1",
                     if_id_pc, mem_pc, if_id_inst, if_id_valid, mem[65535]);
        end
    endtask

    task automatic test_reset_mid();
        repeat (3) step(0, 0, 16'h0000, 0, 0);
        step(1, 1, 16'h1234, 1, 1);
        n_cmp++;
        if (mem_pc !== 16'h0000 || if_id_pc !== 16'h0000 || if_id_inst !== NOP ||
            if_id_valid !== 1'b0 || fetch_cnt !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_mid: got pc=%h ipc=%h inst=%h v=%b cnt=%h, want all reset values",
                     mem_pc, if_id_pc, if_id_inst, if_id_valid, fetch_cnt);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic r, b, s, bz;
            logic [15:0] t;
            r  = ($urandom_range(0, 49) == 0);
            b  = ($urandom_range(0, 9) == 0);
            s  = ($urandom_range(0, 4) == 0);
            bz = ($urandom_range(0, 4) == 0);
            t  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(65530, 65535))
                                             : 16'($urandom);
            step(r, b, t, s, bz);
            n_cmp++;
            if (mem_pc !== m_pc || if_id_pc !== m_ipc || if_id_inst !== m_inst ||
                if_id_valid !== m_val || fetch_cnt !== m_cnt) begin
                n_bad++;
                $display("FAIL random[%0d]: got pc=%h ipc=%h inst=%h v=%b cnt=%h want pc=%h ipc=%h inst=%h v=%b cnt=%h",
                         i, mem_pc, if_id_pc, if_id_inst, if_id_valid, fetch_cnt,
                         m_pc, m_ipc, m_inst, m_val, m_cnt);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 65540; i++) begin
            step(0, 0, 16'h0000, 0, 0);
            if (i == 65533 || i == 65534 || i == 65539) begin
                n_cmp++;
                if (fetch_cnt !== m_cnt || if_id_pc !== m_ipc || if_id_inst !== m_inst) begin
                    n_bad++;
                    $display("FAIL saturate[%0d]: got cnt=%h ipc=%h inst=%h want cnt=%h ipc=%h inst=%h",
                             i, fetch_cnt, if_id_pc, if_id_inst, m_cnt, m_ipc, m_inst);
                end
            end
        end
        n_cmp++;
        if (fetch_cnt !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL saturate_final: got %h want ffff", fetch_cnt);
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
        mem[0] = 16'h6801; mem[1] = 16'h6902; mem[2] = 16'h6A03;
        m_pc = 16'h0000; m_ipc = 16'h0000; m_inst = NOP; m_val = 1'b0; m_cnt = 16'h0000;
        #1;
        test_reset();
        test_straight_line();
        test_stall();
        test_busy();
        test_redirect();
        test_wrap();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch (IF) stage of the 16-bit pipelined CPU. It holds the program counter and drives it to the instruction memory port. It samples the returned instruction and loads the IF/ID pipeline register. It also handles stall, branch redirect and memory-busy bubbles, and keeps a saturating fetch counter for bring-up debug. It is the initiator side of the combinational instruction-memory read port: `pc` out, `inst` back in the same cycle.

## Interface
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `NOP_INST`, default 16'h0800: encoding inserted as a bubble.
- `clk` input, 1: single clock; all state updates on the rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `stall` input, 1: hazard unit requests that PC and IF/ID hold.
- `branch_en` input, 1: redirect request from a later stage.
- `branch_target` input, `PC_BUS` (16): redirect address.
- `mem_busy` input, 1: the shared RAM is taken by a data access this cycle, so no fetch is possible.
- `mem_pc` output, `PC_BUS` (16): address to instruction memory.
- `mem_inst` input, `INST_BUS` (16): instruction returned combinationally for `mem_pc`.
- `if_id_pc` output, 16: address of the fetched instruction plus 1.
- `if_id_inst` output, 16: fetched instruction, or `NOP_INST`.
- `if_id_valid` output, 1: 1 when `if_id_inst` is a real fetched instruction.
- `fetch_cnt` output, 16: number of accepted fetches, saturating.

## Operation
- `mem_pc` is a combinational copy of the internal `pc` register. There is no other combinational path from input to output.
- Per-cycle priority: `rst` > `branch_en` > `stall` > `mem_busy` > normal fetch.
- **Reset:**
  - `pc` <= `RESET_PC`.
  - `if_id_pc` <= 0, `if_id_inst` <= `NOP_INST`, `if_id_valid` <= 0.
  - `fetch_cnt` <= 0.
- **Redirect** (`branch_en`=1):
  - `pc` <= `branch_target`.
  - IF/ID is loaded with the bubble: `NOP_INST`, valid 0, `if_id_pc` 0.
  - The wrong-path instruction at the old `pc` is discarded and not counted.
  - Redirect takes effect even when `stall`=1 or `mem_busy`=1.
- **Stall** (`stall`=1, no redirect): `pc`, `if_id_*` and `fetch_cnt` all hold.
- **Busy** (`mem_busy`=1, no stall, no redirect):
  - `pc` holds.
  - IF/ID is loaded with the bubble (valid 0).
  - `fetch_cnt` holds.
- **Normal fetch:**
  - `if_id_inst` <= `mem_inst`, `if_id_pc` <= `pc`+1, `if_id_valid` <= 1.
  - `pc` <= `pc`+1.
  - `fetch_cnt` <= `fetch_cnt`+1, saturating at 16'hFFFF.
- **Arithmetic:**
  - `pc`+1 is modulo 2^16, so 16'hFFFF wraps to 16'h0000, both in `pc` and in `if_id_pc`.
  - `branch_target` is used unmodified; there is no alignment check.
- The block never decodes `mem_inst` and passes any value through unchanged.

## Timing
- Fetch latency is 1 cycle: `mem_inst` is sampled at the edge that ends the cycle in which `mem_pc` is presented. The memory must return valid data in the same cycle.
- Throughput is 1 instruction per cycle with no stall and no busy.
- A redirect asserted in cycle N gives `mem_pc` = `branch_target` in cycle N+1. The first target instruction appears in IF/ID in cycle N+2, with one bubble in cycle N+1.
- While `stall` stays high, the IF/ID outputs are stable for as many cycles as it is held. Release resumes fetch at the held `pc` with no skipped or duplicated instruction.
- Reset asserted mid-stream takes effect at the next edge regardless of the other inputs. `mem_pc` = `RESET_PC` from the following cycle.
- Simultaneous `stall` and `mem_busy`: stall wins, and IF/ID holds rather than bubbling.

## Test plan
- **Reset and straight-line fetch:**
  - Setup: memory holds [0]=16'h6801, [1]=16'h6902, [2]=16'h6A03; `rst` high 2 cycles, then low.
  - Cycle 0: `mem_pc` = 0; all outputs at reset values before release.
  - Following cycles: IF/ID shows (1, 6801, v1), (2, 6902, v1), (3, 6A03, v1); `fetch_cnt` = 3.
- **Stall:**
  - Stimulus: `stall` for 3 cycles after the first fetch.
  - Response: IF/ID stays (1, 6801, v1) and `mem_pc` stays 1 for 3 cycles; then (2, 6902) follows, with no duplicates.
- **Mem busy:**
  - Stimulus: `mem_busy` for 1 cycle at `pc`=1.
  - Response: one bubble (16'h0800, valid 0), `mem_pc` held at 1, next (2, 6902); `fetch_cnt` not incremented for the bubble.
- **Redirect:**
  - Stimulus: `branch_en` with target 16'h0002 while `pc`=5 and `stall`=1.
  - Response: next `mem_pc` = 2; IF/ID bubble; then (3, 6A03, v1).
- **Wrap-around:**
  - Stimulus: redirect to 16'hFFFF, then fetch.
  - Response: `if_id_pc` = 16'h0000 and `mem_pc` = 16'h0000.
- **Reset mid-stream and counter saturation:**
  - Reset mid-stream: assert `rst` during a busy cycle; all outputs return to reset values at the next edge.
  - Saturation: force 65540 fetches; `fetch_cnt` sticks at 16'hFFFF.
